insn_byte_loader: RTL and testbench

INSN_BYTE_LOADER -- requirements
Module: insn_byte_loader

---
 rtl/insn_byte_loader_if.sv | 24 ++
 rtl/insn_byte_loader.sv | 148 ++++++++++++++
 tb/tb_insn_byte_loader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/insn_byte_loader_if.sv
// Fetch-side handshake and instruction-memory byte bus for insn_byte_loader.
// master = requester/memory side, slave = the loader.
interface insn_byte_loader_if;
   logic        start;
   logic [63:0] PC;
   logic        mem_rd;
   logic [63:0] mem_addr;
   logic [7:0]  mem_data;
   logic        busy;
   logic        done;
   logic [0:79] Instruction;
   logic [3:0]  len;
   logic        ADR;

   modport master (
      output start, PC, mem_data,
      input  mem_rd, mem_addr, busy, done, Instruction, len, ADR
   );

   modport slave (
      input  start, PC, mem_data,
      output mem_rd, mem_addr, busy, done, Instruction, len, ADR
   );
endinterface

// File: rtl/insn_byte_loader.sv
// Loads one variable-length instruction byte-by-byte from a synchronous-read memory.
// Two cycles per byte plus start/done overhead; start is ignored while busy.
module insn_byte_loader #(
   parameter int MemSize = 1024
) (
   input logic           Clk,
   input logic           Rst,
   insn_byte_loader_if.slave bus
);

   typedef enum logic [1:0] {IDLE, READ, CAPT, DONE} state_t;

   state_t      state_q, state_d;
   logic [63:0] base_q, base_d;
   logic [3:0]  idx_q, idx_d;
   logic [3:0]  tgt_q, tgt_d;
   logic        mem_rd_q, mem_rd_d;
   logic [63:0] mem_addr_q, mem_addr_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [0:79] instr_q, instr_d;
   logic [3:0]  len_q, len_d;
   logic        adr_q, adr_d;

   logic [63:0] rd_base;
   logic [3:0]  rd_idx;
   logic [64:0] rd_sum;
   logic        rd_ok;
   logic [3:0]  t_dec;

   function automatic logic [3:0] decode_len(input logic [3:0] icode);
      case (icode)
         4'h2, 4'h6, 4'hA, 4'hB: decode_len = 4'd2;
         4'h7, 4'h8:             decode_len = 4'd9;
         4'h3, 4'h4, 4'h5:       decode_len = 4'd10;
         default:                decode_len = 4'd1;
      endcase
   endfunction

   // Address of the read being scheduled for the next READ cycle; the range
   // check is done here so mem_rd can be a registered output.
   always_comb begin
      rd_base = (state_q == IDLE) ? bus.PC : base_q;
      rd_idx  = (state_q == IDLE) ? 4'd0 : idx_q + 4'd1;
      rd_sum  = {1'b0, rd_base} + 65'(rd_idx);
      rd_ok   = !rd_sum[64] && (rd_sum[63:0] < 64'(MemSize));
      t_dec   = (idx_q == 4'd0) ? decode_len(bus.mem_data[7:4]) : tgt_q;
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      idx_d      = idx_q;
      tgt_d      = tgt_q;
      mem_rd_d   = 1'b0;
      mem_addr_d = 64'd0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      instr_d    = instr_q;
      len_d      = len_q;
      adr_d      = adr_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d    = READ;
               base_d     = bus.PC;
               idx_d      = 4'd0;
               tgt_d      = 4'd0;
               instr_d    = '0;
               len_d      = 4'd0;
               adr_d      = 1'b0;
               busy_d     = 1'b1;
               mem_rd_d   = rd_ok;
               mem_addr_d = rd_ok ? rd_sum[63:0] : 64'd0;
            end
         end
         READ: begin
            if (mem_rd_q) begin
               state_d = CAPT;
            end else begin
               state_d = DONE;
               adr_d   = 1'b1;
               done_d  = 1'b1;
            end
         end
         CAPT: begin
            instr_d[{idx_q, 3'b000} +: 8] = bus.mem_data;
            len_d = len_q + 4'd1;
            tgt_d = t_dec;
            if (idx_q + 4'd1 == t_dec) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               state_d    = READ;
               idx_d      = idx_q + 4'd1;
               mem_rd_d   = rd_ok;
               mem_addr_d = rd_ok ? rd_sum[63:0] : 64'd0;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q    <= IDLE;
         base_q     <= 64'd0;
         idx_q      <= 4'd0;
         tgt_q      <= 4'd0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= 64'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         instr_q    <= '0;
         len_q      <= 4'd0;
         adr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         idx_q      <= idx_d;
         tgt_q      <= tgt_d;
         mem_rd_q   <= mem_rd_d;
         mem_addr_q <= mem_addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         instr_q    <= instr_d;
         len_q      <= len_d;
         adr_q      <= adr_d;
      end
   end

   assign bus.mem_rd      = mem_rd_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.Instruction = instr_q;
   assign bus.len         = len_q;
   assign bus.ADR         = adr_q;

endmodule

// File: tb/tb_insn_byte_loader.sv
// Bench for insn_byte_loader: directed corner fetches plus random fetches
// compared against a byte-walk reference model of the instruction memory.
module tb_insn_byte_loader;

   logic Clk;
   logic Rst;
   insn_byte_loader_if bus();

   insn_byte_loader #(.MemSize(1024)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   logic [7:0]  mem [0:1023];
   int          lut [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
   int          cyc = 0;
   int          b2b = 0;
   logic        prev_rd = 1'b0;
   logic [63:0] addr_log [$];

   int          vectors = 0;
   int          miscompares = 0;

   int          exp_cyc;
   logic [3:0]  exp_len;
   logic        exp_adr;
   logic [0:79] exp_ins;
   logic [63:0] exp_addrs [$];

   // Synchronous-read memory: data appears the cycle after the strobe.
   always @(posedge Clk) begin
      cyc++;
      if (bus.mem_rd === 1'b1) begin
         addr_log.push_back(bus.mem_addr);
         if (prev_rd) b2b++;
         bus.mem_data <= mem[bus.mem_addr[9:0]];
      end else begin
         bus.mem_data <= 8'($urandom);
      end
      prev_rd = (bus.mem_rd === 1'b1);
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Walk the bytes from pc until the decoded length is reached or the
   // address leaves the memory.
   task automatic model(input logic [63:0] pc);
      logic [64:0] a;
      int t;
      t = 10;
      exp_len = 4'd0;
      exp_adr = 1'b0;
      exp_ins = '0;
      exp_cyc = 0;
      exp_addrs.delete();
      for (int i = 0; i < 10; i++) begin
         a = {1'b0, pc} + 65'(i);
         if (a >= 65'd1024) begin
            exp_adr = 1'b1;
            exp_cyc = 3 + 2 * i;
            break;
         end
         exp_addrs.push_back(a[63:0]);
         exp_ins[8*i +: 8] = mem[a[9:0]];
         exp_len = exp_len + 4'd1;
         if (i == 0) t = lut[mem[a[9:0]][7:4]];
         if (i + 1 == t) begin
            exp_cyc = 2 * t + 2;
            break;
         end
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_mem_rd"},   128'(bus.mem_rd),      128'(0));
      check({tag, "_mem_addr"}, 128'(bus.mem_addr),    128'(0));
      check({tag, "_busy"},     128'(bus.busy),        128'(0));
      check({tag, "_done"},     128'(bus.done),        128'(0));
      check({tag, "_instr"},    128'(bus.Instruction), 128'(0));
      check({tag, "_len"},      128'(bus.len),         128'(0));
      check({tag, "_adr"},      128'(bus.ADR),         128'(0));
   endtask

   // Cycle 1 is the cycle in which start is presented.
   task automatic run_fetch(input logic [63:0] pc, input bit hold, input string tag);
      int t0;
      int n;
      model(pc);
      @(negedge Clk);
      bus.start = 1'b1;
      bus.PC    = pc;
      addr_log.delete();
      t0 = cyc;
      @(negedge Clk);
      if (!hold) begin
         bus.start = 1'b0;
         bus.PC    = {$urandom, $urandom};
      end
      n = 0;
      while (bus.done !== 1'b1 && n < 40) begin
         @(negedge Clk);
         n++;
      end
      check({tag, "_done_cycle"}, 128'(cyc - t0 + 1), 128'(exp_cyc));
      check({tag, "_len"},   128'(bus.len),         128'(exp_len));
      check({tag, "_adr"},   128'(bus.ADR),         128'(exp_adr));
      check({tag, "_instr"}, 128'(bus.Instruction), 128'(exp_ins));
      check({tag, "_busy_in_done"}, 128'(bus.busy), 128'(1));
      check({tag, "_num_reads"}, 128'(addr_log.size()), 128'(exp_addrs.size()));
      foreach (exp_addrs[i]) begin
         if (i < addr_log.size())
            check({tag, "_rd_addr"}, 128'(addr_log[i]), 128'(exp_addrs[i]));
      end
      @(negedge Clk);
      check({tag, "_done_pulse"}, 128'(bus.done), 128'(0));
      check({tag, "_idle"},       128'(bus.busy), 128'(0));
      check({tag, "_len_hold"},   128'(bus.len),  128'(exp_len));
      check({tag, "_instr_hold"}, 128'(bus.Instruction), 128'(exp_ins));
      if (hold) begin
         @(negedge Clk);
         check({tag, "_restart_accepted"}, 128'(bus.busy), 128'(1));
         bus.start = 1'b0;
         n = 0;
         while (bus.done !== 1'b1 && n < 40) begin
            @(negedge Clk);
            n++;
         end
         check({tag, "_restart_done"}, 128'(bus.done), 128'(1));
         @(negedge Clk);
      end
   endtask

   initial begin
      int dones;
      logic [63:0] pc;
      int r;

      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      bus.mem_data = 8'h00;
      Rst       = 1'b1;
      bus.start = 1'b1;
      bus.PC    = 64'h10;

      // Reset wins over a simultaneous start.
      repeat (3) @(negedge Clk);
      check_outputs_zero("reset");
      Rst       = 1'b0;
      bus.start = 1'b0;
      @(negedge Clk);
      check("reset_start_dropped", 128'(bus.busy), 128'(0));

      mem[16'h10] = 8'h00;
      run_fetch(64'h10, 1'b0, "one_byte");

      mem[16'h20] = 8'h30; mem[16'h21] = 8'hF3; mem[16'h22] = 8'h0A;
      for (int i = 3; i < 10; i++) mem[16'h20 + i] = 8'h00;
      run_fetch(64'h20, 1'b0, "irmovq");

      mem[1020] = 8'h30;
      run_fetch(64'd1020, 1'b0, "mem_end");

      run_fetch(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "pc_max");

      // Reset in the middle of a 9-byte call fetch.
      mem[16'h100] = 8'h80;
      @(negedge Clk);
      bus.start = 1'b1;
      bus.PC    = 64'h100;
      @(negedge Clk);
      bus.start = 1'b0;
      repeat (3) @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      check_outputs_zero("mid_reset");
      dones = 0;
      repeat (25) begin
         @(negedge Clk);
         if (bus.done === 1'b1) dones++;
      end
      check("mid_reset_no_done", 128'(dones), 128'(0));
      run_fetch(64'h0, 1'b0, "after_reset");

      mem[16'h40] = 8'h60; mem[16'h41] = 8'h23;
      run_fetch(64'h40, 1'b1, "start_held");

      for (int k = 0; k < 24; k++) begin
         r = $urandom_range(0, 9);
         if (r < 6)      pc = 64'($urandom_range(0, 1023));
         else if (r < 9) pc = 64'(1014 + $urandom_range(0, 9));
         else            pc = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
         for (int i = 0; i < 10; i++) begin
            if (pc + 64'(i) < 64'd1024) mem[pc[9:0] + 10'(i)] = 8'($urandom);
         end
         run_fetch(pc, 1'b0, "random");
      end

      check("rd_spacing", 128'(b2b), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
